// File: rtl/pcpu_pkg.sv
// Shared constants and types for the CPU instruction-fetch front end.
package pcpu_pkg;

   localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
   localparam int unsigned INST_W = 32;

   typedef struct packed {
      logic [31:0]       pc;
      logic [INST_W-1:0] inst;
   } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible on dout while count != 0.
// Clear takes priority over push and pop in the same cycle.
module ifq_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   // Qualify pop by non-empty; a push into a full queue is only taken alongside a pop.
   always_comb begin
      do_pop  = pop && (count != '0);
      do_push = push && ((count != CW'(DEPTH)) || do_pop);
      dout    = mem[rd_ptr];
   end

   // Storage, pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: issues pipelined in-order imem requests,
// buffers responses in a prefetch queue, and handles redirect squashing.
module ifetch_queue
   import pcpu_pkg::*;
#(
   parameter logic [31:0] TEXT_BASE = TEXT_BASE_DEFAULT,
   parameter int unsigned IMEM_AW   = 11,
   parameter int unsigned DEPTH     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               mem_req,
   output logic [IMEM_AW-1:0] mem_addr,
   input  logic               mem_gnt,
   input  logic               mem_rvalid,
   input  logic [31:0]        mem_rdata,
   output logic               inst_valid,
   output logic [31:0]        inst,
   output logic [31:0]        inst_pc,
   input  logic               inst_ready,
   output logic               fault
);

   localparam int unsigned CW  = $clog2(DEPTH+1);
   localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

   logic [31:0]  fetch_pc;
   logic [31:0]  resp_pc;
   logic [31:0]  off;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop;
   logic [CW-1:0] count;
   logic [CW-1:0] out_next;
   logic [CW:0]   inflight;
   logic          legal;
   logic          run;
   logic          grant;
   logic          push;
   logic          pop;
   ifq_entry_t    head;
   ifq_entry_t    push_entry;

   // Address translation, issue cap and handshake qualification.
   always_comb begin
      off        = fetch_pc - TEXT_BASE;
      legal      = (off[1:0] == 2'b00) && ((off >> (IMEM_AW+2)) == '0);
      mem_addr   = off[IMEM_AW+1:2];
      inflight   = {1'b0, count} + {1'b0, outstanding};
      // run holds requests off for the first cycle after reset so every
      // output sits at its reset value then.
      mem_req    = run && legal && !redirect_valid && (inflight < CAP);
      grant      = mem_req && mem_gnt;
      out_next   = outstanding + CW'(grant) - CW'(mem_rvalid);
      push       = mem_rvalid && (drop == '0);
      inst_valid = (count != '0);
      pop        = inst_valid && inst_ready;
      push_entry = '{pc: resp_pc, inst: mem_rdata};
      inst       = head.inst;
      inst_pc    = head.pc;
   end

   // Fetch/response PCs, in-flight and squash counters, fault flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc    <= TEXT_BASE;
         resp_pc     <= TEXT_BASE;
         outstanding <= '0;
         drop        <= '0;
         fault       <= 1'b0;
         run         <= 1'b0;
      end else begin
         run         <= 1'b1;
         outstanding <= out_next;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            drop     <= out_next;
            fault    <= 1'b0;
         end else begin
            if (grant) fetch_pc <= fetch_pc + 32'd4;
            if (mem_rvalid) begin
               if (drop != '0) drop    <= drop - CW'(1);
               else            resp_pc <= resp_pc + 32'd4;
            end
            if (!legal && (outstanding == '0) && (count == '0)) fault <= 1'b1;
         end
      end
   end

   ifq_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(ifq_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (redirect_valid),
      .push  (push && !redirect_valid),
      .pop   (pop && !redirect_valid),
      .din   (push_entry),
      .dout  (head),
      .count (count)
   );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a configurable-latency imem model.
module tb_ifetch_queue;
   import pcpu_pkg::*;

   localparam logic [31:0] TB_BASE = 32'h0040_0000;
   localparam int unsigned AW      = 11;
   localparam int unsigned DEPTH   = 4;

   logic          clk;
   logic          rst;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [31:0]   mem_rdata;
   logic          inst_valid;
   logic [31:0]   inst;
   logic [31:0]   inst_pc;
   logic          inst_ready;
   logic          fault;

   int tests = 0;
   int fails = 0;
   int lat   = 1;

   ifetch_queue #(
      .TEXT_BASE (TB_BASE),
      .IMEM_AW   (AW),
      .DEPTH     (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_gnt        (mem_gnt),
      .mem_rvalid     (mem_rvalid),
      .mem_rdata      (mem_rdata),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .fault          (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [AW-1:0] a);
      return {16'hC0DE, 5'd0, a};
   endfunction

   // imem: grant at edge E is answered with rvalid sampled at edge E+lat.
   initial begin
      logic          g;
      logic          r;
      logic [AW-1:0] a;
      logic          pv [4];
      logic [AW-1:0] pa [4];
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      for (int i = 0; i < 4; i++) begin
         pv[i] = 1'b0;
         pa[i] = '0;
      end
      forever begin
         @(posedge clk);
         g = mem_req && mem_gnt;
         a = mem_addr;
         r = rst;
         #1;
         if (!r) begin
            for (int i = 0; i < 4; i++) pv[i] = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
         end else begin
            for (int i = 3; i > 0; i--) begin
               pv[i] = pv[i-1];
               pa[i] = pa[i-1];
            end
            pv[0] = g;
            pa[0] = a;
            mem_rvalid = pv[lat-1];
            mem_rdata  = pv[lat-1] ? word_of(pa[lat-1]) : 32'd0;
         end
      end
   end

   // Occupancy invariants: queued plus in-flight never exceed DEPTH.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && ((int'(dut.count) + int'(dut.outstanding) > int'(DEPTH)) ||
                     (int'(dut.drop) > int'(DEPTH)))) begin
            fails++;
            $display("FAIL saturation: count=%0d outstanding=%0d drop=%0d, limit %0d",
                     dut.count, dut.outstanding, dut.drop, DEPTH);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_reset(input int l);
      lat            = l;
      rst            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_gnt        = 1'b1;
      inst_ready     = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_reset();
      apply_reset(1);
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
      tests++; if (inst !== 32'd0) begin fails++; $display("FAIL reset_inst: got %h want 0", inst); end
      tests++; if (inst_pc !== 32'd0) begin fails++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
      tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b want 0", fault); end
   endtask

   task automatic test_stream();
      apply_reset(1);
      rst = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (mem_req !== 1'b1 || mem_addr !== AW'(i)) begin
            fails++; $display("FAIL stream_req[%0d]: got req=%b addr=%h want req=1 addr=%h", i, mem_req, mem_addr, AW'(i));
         end
         tests++;
         if (i < 2) begin
            if (inst_valid !== 1'b0) begin
               fails++; $display("FAIL stream_early_valid[%0d]: got %b want 0", i, inst_valid);
            end
         end else if (inst_valid !== 1'b1 || inst_pc !== TB_BASE + 32'(4*(i-2)) || inst !== word_of(AW'(i-2))) begin
            fails++; $display("FAIL stream_inst[%0d]: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                              i, inst_valid, inst_pc, inst, TB_BASE + 32'(4*(i-2)), word_of(AW'(i-2)));
         end
         tick();
      end
   endtask

   task automatic test_grant_hold();
      apply_reset(1);
      mem_gnt = 1'b0;
      rst     = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (mem_req !== 1'b1 || mem_addr !== AW'(0) || inst_valid !== 1'b0) begin
            fails++; $display("FAIL hold[%0d]: got req=%b addr=%h v=%b want req=1 addr=0 v=0", i, mem_req, mem_addr, inst_valid);
         end
         tick();
      end
      mem_gnt = 1'b1;
      tick();
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== AW'(1)) begin
         fails++; $display("FAIL hold_release: got req=%b addr=%h want req=1 addr=1", mem_req, mem_addr);
      end
   endtask

   task automatic test_backpressure();
      int grants;
      int exp;
      apply_reset(1);
      inst_ready = 1'b0;
      rst        = 1'b1;
      tick();
      grants = 0;
      for (int i = 0; i < 10; i++) begin
         if (mem_req) grants++;
         tick();
      end
      tests++; if (grants !== 4) begin fails++; $display("FAIL bp_grants: got %0d want 4", grants); end
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL bp_req_full: got %b want 0", mem_req); end
      tests++;
      if (inst_valid !== 1'b1 || inst_pc !== TB_BASE || inst !== word_of(AW'(0))) begin
         fails++; $display("FAIL bp_head: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", inst_valid, inst_pc, inst, TB_BASE, word_of(AW'(0)));
      end
      inst_ready = 1'b1;
      tick();
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== AW'(4) || inst_pc !== TB_BASE + 32'd4) begin
         fails++; $display("FAIL bp_resume: got req=%b addr=%h pc=%h want req=1 addr=4 pc=%h", mem_req, mem_addr, inst_pc, TB_BASE + 32'd4);
      end
      exp = 1;
      for (int i = 0; i < 20 && exp < 8; i++) begin
         if (inst_valid) begin
            tests++;
            if (inst_pc !== TB_BASE + 32'(4*exp) || inst !== word_of(AW'(exp))) begin
               fails++; $display("FAIL bp_order[%0d]: got pc=%h inst=%h want pc=%h inst=%h", exp, inst_pc, inst, TB_BASE + 32'(4*exp), word_of(AW'(exp)));
            end
            exp++;
         end
         tick();
      end
      tests++; if (exp !== 8) begin fails++; $display("FAIL bp_drain_timeout: got %0d insts want 8", exp); end
   endtask

   task automatic test_redirect();
      bit found;
      apply_reset(3);
      rst = 1'b1;
      tick();
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0040_0100;
      #1;
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL redir_req_block: got %b want 0", mem_req); end
      tick();
      redirect_valid = 1'b0;
      #1;
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== AW'(11'h040) || inst_valid !== 1'b0) begin
         fails++; $display("FAIL redir_restart: got req=%b addr=%h v=%b want req=1 addr=040 v=0", mem_req, mem_addr, inst_valid);
      end
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         if (inst_valid) begin
            found = 1'b1;
            tests++;
            if (inst_pc !== 32'h0040_0100 || inst !== word_of(AW'(11'h040))) begin
               fails++; $display("FAIL redir_first: got pc=%h inst=%h want pc=00400100 inst=%h", inst_pc, inst, word_of(AW'(11'h040)));
            end
         end else begin
            tick();
         end
      end
      if (!found) begin fails++; $display("FAIL redir_timeout: got no inst want pc=00400100"); end
   endtask

   task automatic test_fault();
      bit found;
      apply_reset(1);
      rst = 1'b1;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0040_0102;
      #1;
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL fault_redir_req: got %b want 0", mem_req); end
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL fault_misaligned_req[%0d]: got %b want 0", i, mem_req); end
         tick();
      end
      tests++;
      if (fault !== 1'b1 || inst_valid !== 1'b0) begin
         fails++; $display("FAIL fault_misaligned: got fault=%b v=%b want fault=1 v=0", fault, inst_valid);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h003F_FFFC;
      tick();
      redirect_valid = 1'b0;
      #1;
      tests++;
      if (fault !== 1'b0 || mem_req !== 1'b0) begin
         fails++; $display("FAIL fault_below_base_clear: got fault=%b req=%b want fault=0 req=0", fault, mem_req);
      end
      tick();
      tick();
      tests++; if (fault !== 1'b1) begin fails++; $display("FAIL fault_below_base: got %b want 1", fault); end
      redirect_valid = 1'b1;
      redirect_pc    = TB_BASE;
      tick();
      redirect_valid = 1'b0;
      #1;
      tests++;
      if (fault !== 1'b0 || mem_req !== 1'b1 || mem_addr !== AW'(0)) begin
         fails++; $display("FAIL fault_recover: got fault=%b req=%b addr=%h want fault=0 req=1 addr=0", fault, mem_req, mem_addr);
      end
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         if (inst_valid) begin
            found = 1'b1;
            tests++;
            if (inst_pc !== TB_BASE || inst !== word_of(AW'(0))) begin
               fails++; $display("FAIL fault_recover_inst: got pc=%h inst=%h want pc=%h inst=%h", inst_pc, inst, TB_BASE, word_of(AW'(0)));
            end
         end else begin
            tick();
         end
      end
      if (!found) begin fails++; $display("FAIL fault_recover_timeout: got no inst want pc=%h", TB_BASE); end
   endtask

   task automatic test_end_of_text();
      logic [31:0] exp;
      logic [31:0] eoff;
      int nreq;
      apply_reset(1);
      rst = 1'b1;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0040_1FF0;
      tick();
      redirect_valid = 1'b0;
      #1;
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== AW'(11'h7FC)) begin
         fails++; $display("FAIL eot_start: got req=%b addr=%h want req=1 addr=7fc", mem_req, mem_addr);
      end
      exp  = 32'h0040_1FF0;
      nreq = 0;
      for (int i = 0; i < 16; i++) begin
         if (mem_req) nreq++;
         if (inst_valid) begin
            eoff = exp - TB_BASE;
            tests++;
            if (inst_pc !== exp || inst !== word_of(eoff[AW+1:2])) begin
               fails++; $display("FAIL eot_inst: got pc=%h inst=%h want pc=%h inst=%h", inst_pc, inst, exp, word_of(eoff[AW+1:2]));
            end
            exp = exp + 32'd4;
         end
         tick();
      end
      tests++; if (exp !== 32'h0040_2000) begin fails++; $display("FAIL eot_count: got next pc %h want 00402000", exp); end
      tests++; if (nreq !== 4) begin fails++; $display("FAIL eot_reqs: got %0d want 4", nreq); end
      tests++;
      if (fault !== 1'b1 || mem_req !== 1'b0) begin
         fails++; $display("FAIL eot_fault: got fault=%b req=%b want fault=1 req=0", fault, mem_req);
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      apply_reset(3);
      rst = 1'b1;
      tick();
      tick();
      tick();
      tick();
      tests++;
      if (mem_req !== 1'b1 || inst_valid !== 1'b0 || mem_addr !== AW'(3)) begin
         fails++; $display("FAIL rmid_pre: got req=%b v=%b addr=%h want req=1 v=0 addr=3", mem_req, inst_valid, mem_addr);
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      tests++;
      if (mem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 32'd0 || fault !== 1'b0) begin
         fails++; $display("FAIL rmid_outputs: got req=%b v=%b inst=%h pc=%h fault=%b want all 0",
                           mem_req, inst_valid, inst, inst_pc, fault);
      end
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         if (inst_valid) begin
            found = 1'b1;
            tests++;
            if (inst_pc !== TB_BASE || inst !== word_of(AW'(0))) begin
               fails++; $display("FAIL rmid_first: got pc=%h inst=%h want pc=%h inst=%h", inst_pc, inst, TB_BASE, word_of(AW'(0)));
            end
         end else begin
            tick();
         end
      end
      if (!found) begin fails++; $display("FAIL rmid_timeout: got no inst want pc=%h", TB_BASE); end
   endtask

   initial begin
      rst            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_gnt        = 1'b1;
      inst_ready     = 1'b1;
      test_reset();
      test_stream();
      test_grant_hold();
      test_backpressure();
      test_redirect();
      test_fault();
      test_end_of_text();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Parametrised instruction-fetch front end between the pipelined CPU core and the instruction memory.
- Translates CPU byte PCs into word indices relative to a configurable text base.
- Issues pipelined, in-order memory requests with a request/grant handshake, and buffers returned instructions in a prefetch queue presented to the core with valid/ready.
- Supports branch redirect with squashing of in-flight fetches, plus an address-fault indication.

Parameters:
TEXT_BASE, 32'h00400000, byte address of instruction word 0 in imem
IMEM_AW, 11, imem word-index width; legal text span is 2^(IMEM_AW+2) bytes
DEPTH, 4, prefetch queue entries; also the cap on (queued + outstanding) fetches; power of two, >= 2

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-low reset
redirect_valid  in  1  core requests fetch restart (branch/jump taken)
redirect_pc  in  32  new fetch byte address
mem_req  out  1  fetch request valid
mem_addr  out  IMEM_AW  word index = (fetch_pc - TEXT_BASE) >> 2
mem_gnt  in  1  imem accepts request this cycle
mem_rvalid  in  1  in-order response valid, at least 1 cycle after its grant
mem_rdata  in  32  instruction word
inst_valid  out  1  queue head valid
inst  out  32  head instruction
inst_pc  out  32  head byte PC
inst_ready  in  1  core consumes head
fault  out  1  fetch stalled on misaligned or out-of-range PC

Behaviour:
- Reset, rst==0 at a clock edge:
  - fetch_pc = resp_pc = TEXT_BASE.
  - Queue empty; outstanding = drop = 0.
  - Outputs: mem_req=0, inst_valid=0, inst=0, inst_pc=0, fault=0.
  - Reset mid-operation discards everything, including later mem_rvalid pulses for pre-reset grants. The imem is reset on the same rst.
- Range check:
  - off = fetch_pc - TEXT_BASE, 32-bit wrap.
  - PC is legal iff off[1:0]==0 and off < 2^(IMEM_AW+2).
  - mem_addr = off[IMEM_AW+1:2], combinational from fetch_pc.
- Request issue:
  - mem_req = legal && !redirect_valid && (count + outstanding < DEPTH).
  - mem_req holds with a stable mem_addr until granted.
  - On mem_req && mem_gnt: fetch_pc += 4 and outstanding += 1.
  - Back-to-back grants are allowed every cycle.
- Response:
  - On mem_rvalid, outstanding -= 1.
  - If drop > 0: drop -= 1 and the word is discarded.
  - Otherwise push {resp_pc, mem_rdata} and resp_pc += 4.
  - Push never overflows because of the issue cap.
  - A grant and a response in the same cycle leave outstanding unchanged.
- Output:
  - Show-ahead FIFO: inst_valid = (count != 0); inst and inst_pc come from the head entry.
  - Pop on inst_valid && inst_ready.
  - Simultaneous push and pop on a full queue is legal: count is unchanged. On an empty queue, the pushed entry is visible the next cycle, giving 1 cycle latency from mem_rvalid to inst_valid.
- Redirect has highest priority:
  - Queue cleared; pop and push that cycle are ignored.
  - drop = outstanding_next, the in-flight count after this cycle's response, excluding any response consumed this cycle.
  - fetch_pc = resp_pc = redirect_pc; no request that cycle.
  - Back-to-back redirects are legal; the last one wins.
- fault:
  - fault = !legal && outstanding==0 && count==0, registered.
  - Stays high until redirect_valid or reset.
  - While fetch_pc is illegal, no request is issued; already-queued legal instructions still drain first.
- Counter widths are $clog2(DEPTH+1). Saturation is impossible by construction and the bench asserts this.

Decomposition:
- Package pcpu_pkg:
  - TEXT_BASE default constant.
  - INST_W=32.
  - Typedef ifq_entry_t {pc[31:0], inst[31:0]}.
- Sub-module ifq_fifo:
  - Parametrised synchronous show-ahead FIFO (DEPTH, entry width).
  - Provides push, pop, clear, count.
  - Instantiated once for the queue storage.
- Issue/response/drop counters stay in ifetch_queue.

Test Plan:
1. Reset release with a 1-cycle-latency imem, mem_gnt=1, inst_ready=1 -> mem_addr 0,1,2,... on consecutive cycles; inst_pc 0x00400000, 0x00400004, ... one per cycle from cycle 2.
2. inst_ready=0 held -> exactly DEPTH=4 grants, then mem_req=0; inst_pc stays 0x00400000. Release ready -> four instructions in order, then fetch resumes.
3. Imem latency 3, redirect_valid with redirect_pc=0x00400100 while 2 fetches are in flight -> the 2 stale responses are dropped; the next inst has inst_pc=0x00400100 and mem_addr=0x40.
4. redirect_pc=0x00400102 -> mem_req stays 0 and fault=1; a subsequent redirect to 0x00400000 clears fault and fetch restarts.
5. Sequential fetch reaching TEXT_BASE+0x2000 with IMEM_AW=11 -> the last word at 0x00401FFC is delivered, then fault=1 with no further request.
6. rst=0 asserted for one cycle with 3 fetches outstanding -> all outputs return to reset values next cycle; fetch restarts at 0x00400000 with no stale instruction delivered.
